// File: rtl/alu_sequencer_if.sv
// ROM fetch port and ALU operand/result port shared by the sequencer (master)
// and the ROM/ALU side (slave).
interface alu_sequencer_if #(parameter int PC_W = 6);
  logic            instr_req;
  logic [PC_W-1:0] instr_addr;
  logic [15:0]     instr_data;
  logic            instr_valid;
  logic [7:0]      alu_a;
  logic [7:0]      alu_b;
  logic [2:0]      alu_sel;
  logic [7:0]      alu_f;
  logic            alu_ovf;
  logic            alu_take_branch;

  modport master (
    output instr_req, instr_addr, alu_a, alu_b, alu_sel,
    input  instr_data, instr_valid, alu_f, alu_ovf, alu_take_branch
  );

  modport slave (
    input  instr_req, instr_addr, alu_a, alu_b, alu_sel,
    output instr_data, instr_valid, alu_f, alu_ovf, alu_take_branch
  );
endinterface

// File: rtl/alu_sequencer.sv
// Multi-cycle control stage for the external 8-bit ALU: fetch, execute, write back,
// with a 4x8 register file and a wrapping PC_W-bit program counter.
//
// state   | meaning
// IDLE    | waiting for start after reset
// FETCH   | ROM request held until instr_valid
// EXEC    | ALU operands driven from IR and registers
// WB      | result/branch applied, PC advanced
// HALT    | halt word fetched, PC parked on it
module alu_sequencer #(
  parameter int PC_W = 6
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_start,
  alu_sequencer_if.master        bus,
  output logic                   o_busy,
  output logic                   o_halted,
  output logic                   o_ovf_flag,
  input  logic [1:0]             i_dbg_sel,
  output logic [7:0]             o_dbg_data
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_EXEC  = 3'd2;
  localparam logic [2:0] S_WB    = 3'd3;
  localparam logic [2:0] S_HALT  = 3'd4;

  logic [2:0]      r_state;
  logic [PC_W-1:0] r_pc;
  // The halt bit is consumed at fetch time, so only op/operands/offset are kept.
  logic [14:0]     r_ir;
  logic [7:0]      r_regs [4];
  logic            r_ovf;

  logic [2:0]      w_op;
  logic [1:0]      w_rd;
  logic [1:0]      w_rs;
  logic [1:0]      w_rt;
  logic            w_is_branch;
  logic [PC_W-1:0] w_off_sx;
  logic [PC_W-1:0] w_pc_inc;
  logic [PC_W-1:0] w_pc_tgt;

  assign w_op        = r_ir[14:12];
  assign w_rd        = r_ir[11:10];
  assign w_rs        = r_ir[9:8];
  assign w_rt        = r_ir[7:6];
  assign w_is_branch = w_op[2] & w_op[1];
  assign w_off_sx    = PC_W'($signed(r_ir[5:0]));
  assign w_pc_inc    = r_pc + PC_W'(1);
  assign w_pc_tgt    = w_pc_inc + w_off_sx;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_ir    <= '0;
      r_ovf   <= 1'b0;
      for (int i = 0; i < 4; i++) r_regs[i] <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_HALT: begin
          if (i_start) begin
            r_pc    <= '0;
            r_ovf   <= 1'b0;
            r_state <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (bus.instr_valid) begin
            r_ir    <= bus.instr_data[14:0];
            r_state <= bus.instr_data[15] ? S_HALT : S_EXEC;
          end
        end
        S_EXEC: r_state <= S_WB;
        S_WB: begin
          if (w_is_branch) begin
            r_pc <= bus.alu_take_branch ? w_pc_tgt : w_pc_inc;
          end else begin
            r_regs[w_rd] <= bus.alu_f;
            r_pc         <= w_pc_inc;
          end
          if (w_op == 3'd0) r_ovf <= r_ovf | bus.alu_ovf;
          r_state <= S_FETCH;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.instr_req  = (r_state == S_FETCH);
  assign bus.instr_addr = r_pc;
  assign bus.alu_a      = r_regs[w_rs];
  assign bus.alu_b      = r_regs[w_rt];
  assign bus.alu_sel    = w_op;

  assign o_busy     = (r_state == S_FETCH) || (r_state == S_EXEC) || (r_state == S_WB);
  assign o_halted   = (r_state == S_HALT);
  assign o_ovf_flag = r_ovf;
  assign o_dbg_data = r_regs[i_dbg_sel];

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: behavioural ALU and ROM on the bus side, an
// instruction-level reference model checked every cycle, plus directed programs.
module tb_alu_sequencer;
  localparam int PC_W = 6;
  localparam logic [15:0] HALT_W = 16'h8000;

  logic       clk = 1'b0;
  logic       i_rst, i_start;
  logic [1:0] i_dbg_sel;
  logic       o_busy, o_halted, o_ovf_flag;
  logic [7:0] o_dbg_data;

  always #5 clk = ~clk;

  alu_sequencer_if #(.PC_W(PC_W)) bus();

  alu_sequencer #(.PC_W(PC_W)) dut (
    .i_clk      (clk),
    .i_rst      (i_rst),
    .i_start    (i_start),
    .bus        (bus.master),
    .o_busy     (o_busy),
    .o_halted   (o_halted),
    .o_ovf_flag (o_ovf_flag),
    .i_dbg_sel  (i_dbg_sel),
    .o_dbg_data (o_dbg_data)
  );

  logic [15:0] rom [64];
  int          total = 0;
  int          bad = 0;
  int          rom_wait = 0;
  int          stall_cnt = 0;
  bit          dbg_hold = 0;
  logic [1:0]  dbg_fix = 2'd0;
  int          q_fetch[$];

  // External combinational ALU
  always_comb begin
    bus.alu_f           = 8'h00;
    bus.alu_ovf         = 1'b0;
    bus.alu_take_branch = 1'b0;
    case (bus.alu_sel)
      3'd0: {bus.alu_ovf, bus.alu_f} = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
      3'd1: bus.alu_f = ~bus.alu_b;
      3'd2: bus.alu_f = bus.alu_a & bus.alu_b;
      3'd3: bus.alu_f = bus.alu_a | bus.alu_b;
      3'd4: bus.alu_f = {bus.alu_a[7], bus.alu_a[7:1]};
      3'd5: bus.alu_f = {bus.alu_a[6:0], 1'b0};
      3'd6: bus.alu_take_branch = (bus.alu_a == bus.alu_b);
      default: bus.alu_take_branch = (bus.alu_a != bus.alu_b);
    endcase
  end

  // ROM responder and debug-index driver
  always @(negedge clk) begin
    i_dbg_sel = dbg_hold ? dbg_fix : i_dbg_sel + 2'd1;
    if (bus.instr_req === 1'b1) begin
      if (rom_wait > 0) begin
        bus.instr_valid = 1'b0;
        rom_wait--;
        stall_cnt++;
      end else begin
        bus.instr_valid = 1'b1;
      end
    end else begin
      bus.instr_valid = 1'b0;
    end
    bus.instr_data = rom[bus.instr_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: architectural state, committed at the end of each instruction
  bit         m_run, m_halt, m_ovf;
  int         m_gap, m_pc;
  logic [7:0] m_r [4];
  logic [15:0] m_ir;
  bit         p_wr, p_ovf;
  int         p_rd, p_pc;
  logic [7:0] p_val;

  task automatic model_issue(input logic [15:0] w);
    int op, off, a, b, s;
    bit take;
    m_ir = w;
    if (w[15]) begin
      m_run  = 0;
      m_halt = 1;
    end else begin
      op    = int'(w[14:12]);
      a     = int'(m_r[w[9:8]]);
      b     = int'(m_r[w[7:6]]);
      off   = w[5] ? int'(w[5:0]) - 64 : int'(w[5:0]);
      p_rd  = int'(w[11:10]);
      p_wr  = (op < 6);
      p_ovf = 0;
      take  = 0;
      s     = 0;
      case (op)
        0: begin s = a + b; p_ovf = (s > 255); end
        1: s = 255 - b;
        2: s = a & b;
        3: s = a | b;
        4: s = (a / 2) + (a >= 128 ? 128 : 0);
        5: s = a * 2;
        6: take = (a == b);
        default: take = (a != b);
      endcase
      p_val = s[7:0];
      p_pc  = take ? (((m_pc + 1 + off) % 64) + 64) % 64 : (m_pc + 1) % 64;
      m_gap = 2;
    end
  endtask

  always begin
    @(negedge clk);
    #3;
    if (i_rst) begin
      m_run = 0; m_halt = 0; m_ovf = 0; m_gap = 0; m_pc = 0; m_ir = '0;
      for (int i = 0; i < 4; i++) m_r[i] = 8'h00;
    end else begin
      chk("busy", o_busy, m_run);
      chk("halted", o_halted, m_halt);
      chk("instr_req", bus.instr_req, m_run && m_gap == 0);
      chk("instr_addr", bus.instr_addr, m_pc);
      chk("alu_sel", bus.alu_sel, m_ir[14:12]);
      chk("alu_a", bus.alu_a, m_r[m_ir[9:8]]);
      chk("alu_b", bus.alu_b, m_r[m_ir[7:6]]);
      chk("ovf_flag", o_ovf_flag, m_ovf);
      chk("dbg_data", o_dbg_data, m_r[i_dbg_sel]);
      if (m_run && m_gap == 0) begin
        if (bus.instr_valid) begin
          q_fetch.push_back(m_pc);
          model_issue(rom[m_pc]);
        end
      end else if (m_run) begin
        m_gap--;
        if (m_gap == 0) begin
          if (p_wr) m_r[p_rd] = p_val;
          m_ovf = m_ovf | p_ovf;
          m_pc  = p_pc;
        end
      end else if (i_start) begin
        m_run = 1; m_halt = 0; m_pc = 0; m_ovf = 0;
      end
    end
  end

  function automatic logic [15:0] enc(input logic [2:0] op, input logic [1:0] rd,
                                      input logic [1:0] rs, input logic [1:0] rt,
                                      input logic [5:0] off);
    return {1'b0, op, rd, rs, rt, off};
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < 64; i++) rom[i] = HALT_W;
  endtask

  task automatic pulse_start();
    @(negedge clk); i_start = 1'b1;
    @(negedge clk); i_start = 1'b0;
  endtask

  task automatic wait_halt(input int maxc, input string nm);
    bit ok = 0;
    for (int i = 0; i < maxc && !ok; i++) begin
      @(negedge clk);
      ok = (o_halted === 1'b1);
    end
    chk({nm, "_halt_seen"}, ok, 1);
  endtask

  task automatic peek(input logic [1:0] idx, input logic [7:0] exp, input string nm);
    dbg_fix = idx;
    dbg_hold = 1;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk(nm, o_dbg_data, exp);
    dbg_hold = 0;
  endtask

  task automatic do_reset();
    @(negedge clk); i_rst = 1'b1;
    @(negedge clk); i_rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit found;
    int nz;
    i_rst = 1'b1; i_start = 1'b0; i_dbg_sel = 2'd0;
    bus.instr_valid = 1'b0; bus.instr_data = 16'h0;
    clear_rom();
    repeat (3) @(negedge clk);
    i_rst = 1'b0;
    @(negedge clk); #1;
    chk("rst_busy", o_busy, 0);
    chk("rst_halted", o_halted, 0);
    chk("rst_req", bus.instr_req, 0);
    chk("rst_sel", bus.alu_sel, 0);
    chk("rst_a", bus.alu_a, 0);

    // 1) R1 = R0 + R0, halt
    clear_rom();
    rom[0] = enc(3'd0, 2'd1, 2'd0, 2'd0, 6'd0);
    pulse_start();
    wait_halt(40, "t1");
    peek(2'd1, 8'h00, "t1_r1");
    chk("t1_pc", bus.instr_addr, 1);
    chk("t1_ovf", o_ovf_flag, 0);

    // 2) R1=FF, R2=01, R3=R1+R2 overflows; later OR keeps ovf; first fetch stalls 3 cycles
    clear_rom();
    rom[0] = enc(3'd1, 2'd1, 2'd0, 2'd0, 6'd0);
    rom[1] = enc(3'd5, 2'd2, 2'd1, 2'd0, 6'd0);
    rom[2] = enc(3'd1, 2'd2, 2'd0, 2'd2, 6'd0);
    rom[3] = enc(3'd0, 2'd3, 2'd1, 2'd2, 6'd0);
    rom[4] = enc(3'd3, 2'd0, 2'd0, 2'd0, 6'd0);
    stall_cnt = 0;
    rom_wait = 3;
    pulse_start();
    wait_halt(60, "t2");
    chk("t2_stalls", stall_cnt, 3);
    peek(2'd3, 8'h00, "t2_r3");
    peek(2'd2, 8'h01, "t2_r2");
    peek(2'd1, 8'hFF, "t2_r1");
    chk("t2_ovf", o_ovf_flag, 1);
    chk("t2_model_r2", m_r[2], 8'h01);
    chk("t2_model_ovf", m_ovf, 1);

    // 3) BEQ R0,R0 +2 at PC 4 -> 7; BNE R0,R0 at PC 4 -> 5
    clear_rom();
    for (int i = 0; i < 4; i++) rom[i] = enc(3'd3, 2'd0, 2'd0, 2'd0, 6'd0);
    rom[4] = enc(3'd6, 2'd0, 2'd0, 2'd0, 6'd2);
    q_fetch.delete();
    pulse_start();
    wait_halt(60, "t3a");
    chk("t3a_pc", bus.instr_addr, 7);
    chk("t3a_nfetch", q_fetch.size(), 6);
    if (q_fetch.size() == 6) chk("t3a_after_branch", q_fetch[5], 7);
    peek(2'd1, 8'hFF, "t3a_r1_kept");
    rom[4] = enc(3'd7, 2'd0, 2'd0, 2'd0, 6'd2);
    pulse_start();
    wait_halt(60, "t3b");
    chk("t3b_pc", bus.instr_addr, 5);
    peek(2'd3, 8'h00, "t3b_r3_kept");

    // 4a) branch to 63, non-branch at 63 wraps to 0
    do_reset();
    clear_rom();
    rom[0]  = enc(3'd6, 2'd0, 2'd0, 2'd2, 6'h3E);
    rom[63] = enc(3'd1, 2'd2, 2'd0, 2'd0, 6'd0);
    q_fetch.delete();
    pulse_start();
    wait_halt(60, "t4a");
    chk("t4a_nfetch", q_fetch.size(), 4);
    if (q_fetch.size() == 4) begin
      chk("t4a_f1", q_fetch[1], 63);
      chk("t4a_f2", q_fetch[2], 0);
      chk("t4a_f3", q_fetch[3], 1);
    end
    peek(2'd2, 8'hFF, "t4a_r2");

    // 4b) build R1=0x80 by shifting, ASR into R2, then BNE R1,R0 -1 self-loop at 0
    clear_rom();
    rom[0] = enc(3'd1, 2'd1, 2'd0, 2'd0, 6'd0);
    for (int i = 1; i <= 7; i++) rom[i] = enc(3'd5, 2'd1, 2'd1, 2'd0, 6'd0);
    rom[8] = enc(3'd4, 2'd2, 2'd1, 2'd0, 6'd0);
    pulse_start();
    wait_halt(100, "t4b");
    peek(2'd1, 8'h80, "t4b_r1");
    peek(2'd2, 8'hC0, "t4b_r2_asr");
    clear_rom();
    rom[0] = enc(3'd7, 2'd0, 2'd1, 2'd0, 6'h3F);
    q_fetch.delete();
    pulse_start();
    repeat (30) @(negedge clk);
    chk("t4b_loop_count", q_fetch.size() >= 9, 1);
    nz = 0;
    foreach (q_fetch[i]) if (q_fetch[i] != 0) nz++;
    chk("t4b_loop_addr", nz, 0);
    chk("t4b_loop_busy", o_busy, 1);

    // 6) rst together with start -> reset wins; then rst in EXEC right after R2 write
    i_rst = 1'b1; i_start = 1'b1;
    @(negedge clk); i_rst = 1'b0; i_start = 1'b0;
    @(negedge clk); #1;
    chk("t6_rst_start_busy", o_busy, 0);
    chk("t6_rst_start_req", bus.instr_req, 0);
    clear_rom();
    rom[0] = enc(3'd1, 2'd2, 2'd0, 2'd0, 6'd0);
    rom[1] = enc(3'd0, 2'd3, 2'd2, 2'd2, 6'd0);
    q_fetch.delete();
    pulse_start();
    pulse_start();
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      found = (q_fetch.size() >= 2);
    end
    chk("t6_reach_exec", found, 1);
    i_rst = 1'b1;
    @(negedge clk); i_rst = 1'b0;
    #1;
    chk("t6_busy", o_busy, 0);
    chk("t6_halted", o_halted, 0);
    chk("t6_ovf", o_ovf_flag, 0);
    peek(2'd2, 8'h00, "t6_r2");
    peek(2'd3, 8'h00, "t6_r3");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
